// File: rtl/feistel_round_sequencer_pkg.sv
// cipher_pkg: sequencer state/mode types and the key-schedule constant tables.
package cipher_pkg;
  typedef enum logic [1:0] {IDLE, KEYEXP, RUN, DONE} seq_state_t;
  typedef enum logic {ENC = 1'b0, DEC = 1'b1} cipher_mode_t;
  localparam int CHAIN_LEN = 24;
  localparam logic [7:0] PINIT [0:7] = '{8'h24, 8'h3F, 8'h6A, 8'h88, 8'h85, 8'hA3, 8'h08, 8'hD3};
  localparam logic [7:0] S_CONST [0:15] = '{8'h13, 8'h19, 8'h8A, 8'h8A, 8'h03, 8'h70, 8'h73, 8'h44,
                                            8'hA4, 8'h09, 8'h38, 8'h22, 8'h29, 8'h9F, 8'h31, 8'hD0};
  function automatic logic [7:0] chain_const(input logic [4:0] e);
    return e < 5'd8 ? PINIT[e[2:0]] : S_CONST[4'(e - 5'd8)];
  endfunction
endpackage

// File: rtl/feistel_round_sequencer_round.sv
// feistel_round: one combinational encrypt or decrypt Feistel round.
module feistel_round
  import cipher_pkg::*;
(
  input  logic [15:0]      t,
  input  cipher_mode_t     mode,
  input  logic [7:0]       pa,
  input  logic [7:0]       pb,
  input  logic [15:0][7:0] s,
  output logic [15:0]      t_next
);
  logic [15:0] u;
  logic [7:0] x, f;
  always_comb begin
    u = mode == DEC ? t ^ {pa, pb} : t;
    x = mode == DEC ? u[7:0] : u[15:8];
    f = s[{2'd0, x[7:6]}] ^ s[{2'd1, x[5:4]}] ^ s[{2'd2, x[3:2]}] ^ s[{2'd3, x[1:0]}];
    t_next = mode == DEC ? {u[7:0], u[15:8] ^ f} : {f ^ u[7:0], u[15:8]} ^ {pa, pb};
  end
endmodule

// File: rtl/feistel_round_sequencer.sv
// feistel_round_sequencer: serial key expansion, then one shared Feistel round per cycle with valid/ready on both sides.
module feistel_round_sequencer
  import cipher_pkg::*;
#(
  parameter int ROUNDS = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] key_in,
  input  logic        key_load,
  output logic        key_ready,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_mode,
  output logic        busy
);
  localparam int RW = $clog2(ROUNDS);
  seq_state_t state;
  cipher_mode_t mode;
  logic [15:0] key, t, t_next;
  logic [4:0] step;
  logic [RW-1:0] round;
  logic [CHAIN_LEN-1:0][7:0] chain;
  logic [1:0] pi;
  logic [7:0] link;
  always_comb begin
    // ROUNDS is a multiple of 4, so (ROUNDS-1-r) mod 4 is just ~r[1:0]
    pi = round[1:0] ^ {2{mode == DEC}};
    // P and S chains each restart at their first element
    link = chain_const(step) ^ (step[0] ? key[15:8] : key[7:0])
         ^ (step == 5'd0 || step == 5'd8 ? 8'd0 : chain[step - 5'd1]);
  end
  assign in_ready = state == IDLE && key_ready && !key_load;
  assign busy = state != IDLE;
  feistel_round u_round (
    .t      (t),
    .mode   (mode),
    .pa     (chain[{2'd0, pi, 1'b0}]),
    .pb     (chain[{2'd0, pi, 1'b1}]),
    .s      (chain[23:8]),
    .t_next (t_next)
  );
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      mode <= ENC;
      key <= '0;
      t <= '0;
      step <= '0;
      round <= '0;
      chain <= '0;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_mode <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (key_load) begin
            key <= key_in;
            key_ready <= 1'b0;
            step <= '0;
            state <= KEYEXP;
          end else if (in_valid && in_ready) begin
            t <= in_data;
            mode <= cipher_mode_t'(in_mode);
            round <= '0;
            state <= RUN;
          end
        KEYEXP: begin
          chain[step] <= link;
          step <= step + 5'd1;
          if (step == 5'(CHAIN_LEN - 1)) begin
            key_ready <= 1'b1;
            state <= IDLE;
          end
        end
        RUN: begin
          t <= t_next;
          round <= round + 1'b1;
          if (round == RW'(ROUNDS - 1)) begin
            out_data <= t_next;
            out_mode <= mode;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE:
          if (out_ready) begin
            out_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_feistel_round_sequencer.sv
// tb_feistel_round_sequencer: scoreboard bench checking the sequencer against a plain-arithmetic cipher model.
module tb_feistel_round_sequencer;
  localparam int ROUNDS = 8;
  localparam logic [7:0] PI_T [8] = '{8'h24, 8'h3F, 8'h6A, 8'h88, 8'h85, 8'hA3, 8'h08, 8'hD3};
  localparam logic [7:0] S_T [16] = '{8'h13, 8'h19, 8'h8A, 8'h8A, 8'h03, 8'h70, 8'h73, 8'h44,
                                      8'hA4, 8'h09, 8'h38, 8'h22, 8'h29, 8'h9F, 8'h31, 8'hD0};
  logic clock = 0, reset_n = 0, key_load = 0, in_valid = 0, in_mode = 0, out_ready = 1;
  logic [15:0] key_in = '0, in_data = '0;
  logic key_ready, in_ready, out_valid, out_mode, busy;
  logic [15:0] out_data, last_out = '0, held;
  logic [16:0] exp_q[$];
  logic [16:0] e;
  logic [7:0] mp [8];
  logic [7:0] ms [16];
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  feistel_round_sequencer #(.ROUNDS(ROUNDS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key_in    (key_in),
    .key_load  (key_load),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .busy      (busy)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Key schedule: two chains (P then S) of const ^ alternating key half ^ previous element
  task automatic set_key(logic [15:0] k);
    for (int i = 0; i < 8; i++)
      mp[i] = PI_T[i] ^ (i % 2 == 1 ? k[15:8] : k[7:0]) ^ (i > 0 ? mp[i-1] : 8'h00);
    for (int j = 0; j < 16; j++)
      ms[j] = S_T[j] ^ (j % 2 == 1 ? k[15:8] : k[7:0]) ^ (j > 0 ? ms[j-1] : 8'h00);
  endtask

  function automatic logic [7:0] f(logic [7:0] x);
    return ms[x[7:6]] ^ ms[4 + x[5:4]] ^ ms[8 + x[3:2]] ^ ms[12 + x[1:0]];
  endfunction

  function automatic logic [15:0] model(logic [15:0] d, logic m);
    logic [7:0] l = d[15:8], r = d[7:0], a, b;
    int p;
    for (int i = 0; i < ROUNDS; i++) begin
      p = m ? (ROUNDS - 1 - i) % 4 : i % 4;
      if (!m) begin
        a = f(l) ^ r ^ mp[2*p];
        b = l ^ mp[2*p+1];
      end else begin
        a = r ^ mp[2*p+1];
        b = l ^ mp[2*p] ^ f(a);
      end
      l = a;
      r = b;
    end
    return {l, r};
  endfunction

  always @(negedge clock)
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got %h want none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e[15:0]));
        chk("out_mode", 32'(out_mode), 32'(e[16]));
        last_out = out_data;
      end
    end

  task automatic send(logic [15:0] d, logic m, bit rnd);
    int n = 0;
    in_data = d;
    in_mode = m;
    in_valid = 1;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      @(posedge clock); #1;
      n++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got in_ready=0 want 1");
        in_valid = 0;
        return;
      end
    end
    exp_q.push_back({m, model(d, m)});
    @(posedge clock); #1;
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain_timeout", 32'(n < 100), 1);
  endtask

  task automatic load_key(logic [15:0] k, logic with_valid);
    int n = 0;
    bit bad = 0;
    key_in = k;
    key_load = 1;
    in_valid = with_valid;
    in_data = 16'h5555;
    in_mode = 0;
    @(negedge clock);
    chk("in_ready_keyload", 32'(in_ready), 0);
    @(posedge clock); #1;
    key_load = 0;
    in_valid = 0;
    set_key(k);
    while (!key_ready && n < 40) begin
      if (!busy || in_ready) bad = 1;
      @(posedge clock); #1;
      n++;
    end
    chk("keyexp_cycles", 32'(n), 24);
    chk("keyexp_busy_inready", 32'(bad), 0);
    chk("in_ready_after_key", 32'(in_ready), 1);
  endtask

  initial begin
    bit bad;
    int n;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_key_ready", 32'(key_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_mode", 32'(out_mode), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    reset_n = 1;
    @(posedge clock); #1;
    load_key(16'h1234, 0);
    // Encrypt with exact latency
    send(16'hABCD, 0, 0);
    bad = 0;
    for (int i = 1; i < ROUNDS; i++) begin
      @(posedge clock); #1;
      if (out_valid) bad = 1;
    end
    chk("latency_early", 32'(bad), 0);
    @(posedge clock); #1;
    chk("latency_valid", 32'(out_valid), 1);
    wait_idle();
    send(last_out, 1, 0);
    wait_idle();
    chk("roundtrip", 32'(last_out), 32'h0000ABCD);
    // Backpressure
    out_ready = 0;
    send(16'h0F0F, 0, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("bp_valid", 32'(out_valid), 1);
    held = out_data;
    repeat (5) begin
      @(posedge clock); #1;
      chk("bp_hold_data", 32'(out_data), 32'(held));
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1;
    @(posedge clock); #1;
    chk("bp_release_in_ready", 32'(in_ready), 1);
    chk("bp_no_dup", 32'(out_valid), 0);
    @(posedge clock); #1;
    chk("bp_no_dup2", 32'(out_valid), 0);
    chk("out_data_kept", 32'(out_data), 32'(held));
    // key_load collides with in_valid in IDLE
    load_key(16'hBEEF, 1);
    // key_load ignored during RUN
    send(16'h1357, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    key_in = 16'h0000;
    key_load = 1;
    @(posedge clock); #1;
    key_load = 0;
    wait_idle();
    chk("key_ready_kept", 32'(key_ready), 1);
    send(16'h2468, 1, 0);
    wait_idle();
    // Random traffic with random backpressure
    load_key(16'($urandom), 0);
    for (int i = 0; i < 30; i++) send(16'($urandom), 1'($urandom_range(0, 1)), 1);
    out_ready = 1;
    wait_idle();
    // Reset in the middle of a block
    send(16'hCAFE, 0, 0);
    repeat (4) @(posedge clock);
    #1;
    reset_n = 0;
    @(posedge clock); #1;
    exp_q.delete();
    reset_n = 1;
    chk("mrst_key_ready", 32'(key_ready), 0);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_out_data", 32'(out_data), 0);
    chk("mrst_out_mode", 32'(out_mode), 0);
    chk("mrst_busy", 32'(busy), 0);
    in_valid = 1;
    bad = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (busy || in_ready || out_valid) bad = 1;
    end
    in_valid = 0;
    chk("mrst_ignore_valid", 32'(bad), 0);
    load_key(16'h1234, 0);
    send(16'hABCD, 0, 0);
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
